// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, TX/RX state encodings and the 2-of-3 vote shared by the UART core
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_EVAL, RX_BREAK} rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO; pointers carry an extra wrap bit to tell full from empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with runtime baud divisor and TX/RX FIFOs behind valid/ready
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 tx_busy,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]    OS_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]    OS_MID    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0]    CNT_ONE   = 1;
    localparam logic [DIV_W-1:0] DIV_ONE   = 1;
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = PARITY == PARITY_ODD;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = div_cnt == '0;

    always_ff @(posedge clk)
        if (reset) div_cnt <= '0;
        else div_cnt <= tick ? (baud_div > DIV_ONE ? baud_div - DIV_ONE : '0) : div_cnt - DIV_ONE;

    tx_state_t            tx_state, tx_next;
    logic [CW-1:0]        tx_tcnt;
    logic [3:0]           tx_bcnt;
    logic [DATA_BITS-1:0] tx_sh, tx_head;
    logic                 tx_par, tx_pop, tx_full, tx_empty, tx_bit_end;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_valid && tx_ready), .wr_data(tx_data),
        .pop(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign tx_ready   = !tx_full;
    assign tx_busy    = !tx_empty || tx_state != TX_IDLE;
    assign tx_bit_end = tick && tx_tcnt == OS_LAST;
    assign uart_tx    = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] :
                        tx_state == TX_PARITY ? tx_par : 1'b1;

    // Leaving IDLE only on a tick keeps the start bit exactly OVERSAMPLE ticks long.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE:   if (tick && !tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bcnt == DATA_LAST) tx_next = PARITY == PARITY_NONE ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_bcnt == STOP_LAST) begin
                tx_next = tx_empty ? TX_IDLE : TX_START;
                tx_pop  = !tx_empty;
            end
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_tcnt  <= (tx_state == TX_IDLE || tx_bit_end) ? '0 : tick ? tx_tcnt + CNT_ONE : tx_tcnt;
            tx_bcnt  <= tx_next != tx_state ? '0 : tx_bit_end ? tx_bcnt + 4'd1 : tx_bcnt;
            if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_par <= ^tx_head ^ PAR_ODD;
            end else if (tx_state == TX_DATA && tx_bit_end) tx_sh <= tx_sh >> 1;
        end
    end

    rx_state_t            rx_state, rx_next;
    logic                 rx_meta, rx_s, rx_maj, rx_mid, rx_bit_end;
    logic [CW-1:0]        rx_tcnt;
    logic [3:0]           rx_bcnt;
    logic [1:0]           rx_smp;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_pbit, rx_stop, rx_push, rx_full, rx_empty, par_bad, fe, pe, ov;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .wr_data(rx_sh),
        .pop(rx_valid && rx_ready), .rd_data(rx_data), .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid   = !rx_empty;
    assign rx_busy    = rx_state != RX_IDLE;
    assign rx_maj     = majority3(rx_smp[1], rx_smp[0], rx_s);
    assign rx_mid     = tick && rx_tcnt == OS_MID;
    assign rx_bit_end = tick && rx_tcnt == OS_LAST;
    assign par_bad    = PARITY != PARITY_NONE && ((^rx_sh ^ rx_pbit) != PAR_ODD);

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        fe      = 1'b0;
        pe      = 1'b0;
        ov      = 1'b0;
        case (rx_state)
            RX_IDLE:   if (tick && !rx_s) rx_next = RX_START;
            RX_START:  rx_next = (rx_mid && rx_maj) ? RX_IDLE : rx_bit_end ? RX_DATA : RX_START;
            RX_DATA:   if (rx_bit_end && rx_bcnt == DATA_LAST) rx_next = PARITY == PARITY_NONE ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
            RX_STOP:   if (rx_mid) rx_next = RX_EVAL;
            RX_EVAL:   begin
                rx_next = rx_stop ? RX_IDLE : RX_BREAK;
                fe      = !rx_stop;
                pe      = rx_stop && par_bad;
                ov      = rx_stop && !par_bad && rx_full && !rx_ready;
                rx_push = rx_stop && !par_bad && !ov;
            end
            RX_BREAK:  if (rx_s) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // rx_tcnt is the index of the next tick within the bit; the detecting tick counts as index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            {rx_meta, rx_s} <= 2'b11;
            rx_state        <= RX_IDLE;
            rx_tcnt         <= CNT_ONE;
            rx_bcnt         <= '0;
            rx_smp          <= 2'b11;
            rx_sh           <= '0;
            rx_pbit         <= 1'b0;
            rx_stop         <= 1'b1;
            rx_frame_err    <= 1'b0;
            rx_parity_err   <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            {rx_meta, rx_s} <= {uart_rx, rx_meta};
            rx_state        <= rx_next;
            rx_tcnt         <= rx_state == RX_IDLE ? CNT_ONE : rx_bit_end ? '0 : tick ? rx_tcnt + CNT_ONE : rx_tcnt;
            rx_bcnt         <= rx_next != rx_state ? '0 : rx_bit_end ? rx_bcnt + 4'd1 : rx_bcnt;
            rx_smp          <= tick ? {rx_smp[0], rx_s} : rx_smp;
            if (rx_mid && rx_state == RX_DATA) rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
            if (rx_mid && rx_state == RX_PARITY) rx_pbit <= rx_maj;
            if (rx_mid && rx_state == RX_STOP) rx_stop <= rx_maj;
            rx_frame_err    <= fe;
            rx_parity_err   <= pe;
            rx_overrun      <= ov;
        end
    end
endmodule
